// File: rtl/psram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : psram_pkg
// Brief    : FSM state and grant encodings shared by the PSRAM burst arbiter.
// Revision : 1.0
// ============================================================================
package psram_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ISSUE      = 3'd1,
        WAIT_START = 3'd2,
        WAIT_DONE  = 3'd3,
        RESP       = 3'd4
    } state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/psram_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : psram_rr_pick
// Brief    : Combinational two-way round-robin / fixed-priority winner select.
// Revision : 1.0
// ============================================================================
module psram_rr_pick
    import psram_pkg::*;
(
    input  logic [1:0] pending,
    input  logic       last_grant,
    input  logic       fixed_priority,
    output logic [1:0] winner
);

    // last_grant = 1 means m1 was served most recently, so m0 wins a tie.
    always_comb begin
        winner = GRANT_NONE;
        case (pending)
            2'b01:   winner = GRANT_M0;
            2'b10:   winner = GRANT_M1;
            2'b11:   winner = (fixed_priority || last_grant) ? GRANT_M0 : GRANT_M1;
            default: winner = GRANT_NONE;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/psram_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : psram_burst_arbiter
// Brief    : Shares one PSRAM burst controller between two Wishbone requesters.
// Revision : 1.0
// ============================================================================
module psram_burst_arbiter
    import psram_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int START_TIMEOUT  = 15,
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     m0_cyc_i,
    input  logic                     m0_stb_i,
    input  logic                     m0_we_i,
    input  logic [ADDRESS_WIDTH-1:0] m0_adr_i,
    output logic                     m0_stall_o,
    output logic                     m0_ack_o,
    output logic                     m0_err_o,
    input  logic                     m1_cyc_i,
    input  logic                     m1_stb_i,
    input  logic                     m1_we_i,
    input  logic [ADDRESS_WIDTH-1:0] m1_adr_i,
    output logic                     m1_stall_o,
    output logic                     m1_ack_o,
    output logic                     m1_err_o,
    output logic                     ctl_cyc_o,
    output logic                     ctl_stb_o,
    output logic                     ctl_we_o,
    output logic [ADDRESS_WIDTH-1:0] ctl_adr_o,
    input  logic                     ctl_busy_i,
    output logic [1:0]               grant_o
);

    localparam int               C_CNT_W   = $clog2(START_TIMEOUT + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(START_TIMEOUT);
    localparam logic [C_CNT_W-1:0] C_CNT_END = C_CNT_W'(START_TIMEOUT - 1);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [1:0]               r_grant;
    logic                     r_last_grant;
    logic [ADDRESS_WIDTH-1:0] r_adr;
    logic                     r_we;
    logic [C_CNT_W-1:0]       r_cnt;
    logic [1:0]               w_pending;
    logic [1:0]               w_winner;
    logic                     w_take;
    logic                     w_timeout;

    assign w_pending = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};

    psram_rr_pick u_pick (
        .pending        (w_pending),
        .last_grant     (r_last_grant),
        .fixed_priority (FIXED_PRIORITY),
        .winner         (w_winner)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // r_cnt counts completed WAIT_START cycles; the last allowed one times out.
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!ctl_busy_i && (w_winner != GRANT_NONE)) begin
                    w_take      = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_state_nxt = WAIT_START;
            end
            WAIT_START: begin
                if (ctl_busy_i) begin
                    w_state_nxt = WAIT_DONE;
                end else if (r_cnt >= C_CNT_END) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!ctl_busy_i) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_grant      <= GRANT_NONE;
            r_last_grant <= 1'b1;
            r_adr        <= '0;
            r_we         <= 1'b0;
            r_cnt        <= '0;
        end else begin
            if (w_take) begin
                r_grant      <= w_winner;
                r_last_grant <= w_winner[1];
                r_adr        <= w_winner[1] ? m1_adr_i : m0_adr_i;
                r_we         <= w_winner[1] ? m1_we_i : m0_we_i;
            end else if (w_state_nxt == IDLE) begin
                r_grant <= GRANT_NONE;
            end

            if (r_state != WAIT_START) begin
                r_cnt <= '0;
            end else if (r_cnt != C_CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // r_grant is non-zero only outside IDLE, so it doubles as the ownership flag.
    always_comb begin
        ctl_cyc_o  = 1'b0;
        ctl_stb_o  = 1'b0;
        ctl_we_o   = r_we;
        ctl_adr_o  = r_adr;
        grant_o    = r_grant;
        m0_stall_o = ~r_grant[0];
        m1_stall_o = ~r_grant[1];
        m0_ack_o   = (r_state == RESP) & r_grant[0];
        m1_ack_o   = (r_state == RESP) & r_grant[1];
        m0_err_o   = w_timeout & r_grant[0];
        m1_err_o   = w_timeout & r_grant[1];
        case (r_state)
            ISSUE: begin
                ctl_cyc_o = 1'b1;
                ctl_stb_o = 1'b1;
            end
            WAIT_START, WAIT_DONE: begin
                ctl_cyc_o = 1'b1;
            end
            default: begin
                ctl_cyc_o = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_psram_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_psram_burst_arbiter
// Brief    : Scoreboard bench with a behavioural controller model and arbiter model.
// Revision : 1.0
// ============================================================================
module tb_psram_burst_arbiter;
    import psram_pkg::*;

    localparam int AW = 16;
    localparam int TO = 15;

    typedef struct {
        int          port;
        logic [AW-1:0] adr;
        logic        we;
        int          s;
        int          b;
        bit          to;
    } burst_t;

    typedef struct {
        int          port;
        bit          is_err;
        longint      due;
        logic [AW-1:0] adr;
    } resp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          m0_cyc = 0, m0_stb = 0, m0_we = 0;
    logic [AW-1:0] m0_adr = '0;
    logic          m1_cyc = 0, m1_stb = 0, m1_we = 0;
    logic [AW-1:0] m1_adr = '0;
    logic          m0_stall, m0_ack, m0_err, m1_stall, m1_ack, m1_err;
    logic          ctl_cyc, ctl_stb, ctl_we, ctl_busy;
    logic [AW-1:0] ctl_adr;
    logic [1:0]    grant;
    logic          busy_bfm = 0, stuck_busy = 0;
    assign ctl_busy = busy_bfm | stuck_busy;

    psram_burst_arbiter #(.ADDRESS_WIDTH(AW), .START_TIMEOUT(TO), .FIXED_PRIORITY(1'b0)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
        .m0_stall_o(m0_stall), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
        .m1_stall_o(m1_stall), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .ctl_cyc_o(ctl_cyc), .ctl_stb_o(ctl_stb), .ctl_we_o(ctl_we), .ctl_adr_o(ctl_adr),
        .ctl_busy_i(ctl_busy), .grant_o(grant)
    );

    // Second instance with fixed priority, driven by its own directed process.
    logic          f_rst = 1'b1;
    logic          f_m0_cyc = 0, f_m0_stb = 0, f_m0_we = 0;
    logic [AW-1:0] f_m0_adr = '0;
    logic          f_m1_cyc = 0, f_m1_stb = 0, f_m1_we = 0;
    logic [AW-1:0] f_m1_adr = '0;
    logic          f_m0_stall, f_m0_ack, f_m0_err, f_m1_stall, f_m1_ack, f_m1_err;
    logic          f_cyc, f_stb, f_we, f_busy = 0;
    logic [AW-1:0] f_adr;
    logic [1:0]    f_grant;
    bit            fp_done = 0;

    psram_burst_arbiter #(.ADDRESS_WIDTH(AW), .START_TIMEOUT(TO), .FIXED_PRIORITY(1'b1)) dut_fp (
        .clk_i(clk), .rst_i(f_rst),
        .m0_cyc_i(f_m0_cyc), .m0_stb_i(f_m0_stb), .m0_we_i(f_m0_we), .m0_adr_i(f_m0_adr),
        .m0_stall_o(f_m0_stall), .m0_ack_o(f_m0_ack), .m0_err_o(f_m0_err),
        .m1_cyc_i(f_m1_cyc), .m1_stb_i(f_m1_stb), .m1_we_i(f_m1_we), .m1_adr_i(f_m1_adr),
        .m1_stall_o(f_m1_stall), .m1_ack_o(f_m1_ack), .m1_err_o(f_m1_err),
        .ctl_cyc_o(f_cyc), .ctl_stb_o(f_stb), .ctl_we_o(f_we), .ctl_adr_o(f_adr),
        .ctl_busy_i(f_busy), .grant_o(f_grant)
    );

    int     errors = 0;
    int     checks = 0;
    longint cyc = 0;
    int     last_grant = 1;
    burst_t issue_q[$];
    burst_t plan_q[$];
    resp_t  resp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input longint act, input longint exp);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Controller model: busy rises s cycles after the strobe and stays high b cycles.
    initial begin : ctl_model
        int     phase;
        int     cnt;
        burst_t p;
        phase = 0;
        cnt   = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                phase    = 0;
                busy_bfm = 0;
                plan_q.delete();
            end else begin
                case (phase)
                    0: if (ctl_stb && plan_q.size() > 0) begin
                        p = plan_q.pop_front();
                        if (!p.to) begin
                            cnt   = p.s;
                            phase = 1;
                        end
                    end
                    1: begin
                        cnt--;
                        if (cnt == 0) begin
                            busy_bfm = 1;
                            cnt      = p.b;
                            phase    = 2;
                        end
                    end
                    default: begin
                        cnt--;
                        if (cnt == 0) begin
                            busy_bfm = 0;
                            phase    = 0;
                        end
                    end
                endcase
            end
        end
    end

    initial begin : monitor
        int          owner;
        burst_t      e;
        resp_t       r;
        logic [3:0]  ev;
        owner = -1;
        forever begin
            @(negedge clk);
            if (rst) begin
                issue_q.delete();
                resp_q.delete();
                owner = -1;
                continue;
            end
            if (ctl_stb) begin
                if (issue_q.size() == 0) begin
                    fail("unexpected_stb", ctl_adr, 0);
                end else begin
                    e = issue_q.pop_front();
                    chk("stb_grant", grant, (e.port == 0) ? GRANT_M0 : GRANT_M1);
                    chk("stb_adr", ctl_adr, e.adr);
                    chk("stb_we", ctl_we, e.we);
                    chk("stb_cyc", ctl_cyc, 1);
                    owner    = e.port;
                    r.port   = e.port;
                    r.is_err = e.to;
                    r.adr    = e.adr;
                    r.due    = cyc + (e.to ? TO : (e.s + e.b + 1));
                    resp_q.push_back(r);
                end
            end
            chk("m0_stall", m0_stall, owner != 0);
            chk("m1_stall", m1_stall, owner != 1);
            chk("grant", grant, (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00);
            if (m0_ack | m0_err | m1_ack | m1_err) begin
                if (resp_q.size() == 0) begin
                    fail("unexpected_resp", {m0_ack, m0_err, m1_ack, m1_err}, 0);
                end else begin
                    r  = resp_q.pop_front();
                    ev = (r.port == 0) ? (r.is_err ? 4'b0100 : 4'b1000)
                                       : (r.is_err ? 4'b0001 : 4'b0010);
                    chk("resp_pulse", {m0_ack, m0_err, m1_ack, m1_err}, ev);
                    chk("resp_cycle", cyc, r.due);
                    if (!r.is_err) begin
                        chk("ack_ctl_cyc", ctl_cyc, 0);
                        chk("ack_adr_stable", ctl_adr, r.adr);
                    end
                end
                owner = -1;
            end else if (resp_q.size() > 0 && cyc > resp_q[0].due) begin
                fail("resp_missing", cyc, resp_q[0].due);
                void'(resp_q.pop_front());
                owner = -1;
            end
        end
    end

    task automatic drop_req(input int i);
        if (i == 0) begin
            m0_cyc = 0;
            m0_stb = 0;
        end else begin
            m1_cyc = 0;
            m1_stb = 0;
        end
    endtask

    // Requests on the ports in mask are raised together; the arbiter model
    // predicts service order and pushes expectations before the DUT acts.
    task automatic run_round(input bit [1:0] mask, input int stuck,
                             input burst_t e0, input burst_t e1,
                             input bit wd0, input bit wd1);
        burst_t e[2];
        bit     done[2];
        bit     wd[2];
        int     order[$];
        int     first;
        int     n;
        e[0] = e0; e[1] = e1;
        e[0].port = 0; e[1].port = 1;
        wd[0] = wd0; wd[1] = wd1;
        done[0] = !mask[0]; done[1] = !mask[1];
        if (mask == 2'b11) begin
            first = (last_grant == 1) ? 0 : 1;
            order = '{first, 1 - first};
        end else begin
            order = '{mask[0] ? 0 : 1};
        end
        foreach (order[k]) begin
            issue_q.push_back(e[order[k]]);
            plan_q.push_back(e[order[k]]);
            last_grant = order[k];
        end
        @(posedge clk);
        #2;
        if (stuck > 0) stuck_busy = 1;
        if (mask[0]) begin m0_cyc = 1; m0_stb = 1; m0_adr = e[0].adr; m0_we = e[0].we; end
        if (mask[1]) begin m1_cyc = 1; m1_stb = 1; m1_adr = e[1].adr; m1_we = e[1].we; end
        for (int k = 0; k < stuck; k++) begin
            @(posedge clk);
            #2;
            chk("stuck_no_stb", ctl_stb, 0);
            chk("stuck_no_grant", grant, 0);
        end
        stuck_busy = 0;
        n = 0;
        while (!(done[0] && done[1]) && n < 600) begin
            @(posedge clk);
            #2;
            n++;
            for (int i = 0; i < 2; i++) begin
                if (!done[i]) begin
                    if ((i == 0) ? (m0_ack | m0_err) : (m1_ack | m1_err)) begin
                        drop_req(i);
                        done[i] = 1;
                    end else if (wd[i] && !((i == 0) ? m0_stall : m1_stall)) begin
                        if (i == 0) m0_cyc = 0; else m1_cyc = 0;
                        wd[i] = 0;
                    end
                end
            end
        end
        if (!(done[0] && done[1])) begin
            fail("round_timeout", {done[1], done[0]}, 2'b11);
            drop_req(0);
            drop_req(1);
        end
    endtask

    function automatic burst_t rnd_burst(input bit allow_to);
        burst_t b;
        b.port = 0;
        b.adr  = AW'($urandom);
        b.we   = 1'($urandom_range(0, 1));
        b.s    = $urandom_range(1, 8);
        b.b    = $urandom_range(1, 40);
        b.to   = allow_to && ($urandom_range(0, 4) == 0);
        return b;
    endfunction

    function automatic burst_t mk(input logic [AW-1:0] adr, input logic we,
                                  input int s, input int b, input bit to);
        burst_t x;
        x.port = 0; x.adr = adr; x.we = we; x.s = s; x.b = b; x.to = to;
        return x;
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_m0_stall"}, m0_stall, 1);
        chk({tag, "_m1_stall"}, m1_stall, 1);
        chk({tag, "_acks"}, {m0_ack, m1_ack, m0_err, m1_err}, 0);
        chk({tag, "_ctl"}, {ctl_cyc, ctl_stb, ctl_we}, 0);
        chk({tag, "_adr"}, ctl_adr, 0);
        chk({tag, "_grant"}, grant, 0);
    endtask

    initial begin : fp_test
        int n;
        repeat (2) @(posedge clk);
        #3 f_rst = 0;
        f_m0_cyc = 1; f_m0_stb = 1; f_m0_adr = 16'h0AA0; f_m0_we = 0;
        f_m1_cyc = 1; f_m1_stb = 1; f_m1_adr = 16'h0BB0; f_m1_we = 1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                @(posedge clk);
                #2;
                n++;
            end while (!f_stb && n < 50);
            chk("fp_grant", f_grant, GRANT_M0);
            chk("fp_adr", f_adr, 16'h0AA0);
            chk("fp_m1_stall", f_m1_stall, 1);
            @(posedge clk);
            #1 f_busy = 1;
            repeat (3) @(posedge clk);
            #1 f_busy = 0;
            n = 0;
            do begin
                @(posedge clk);
                #2;
                n++;
            end while (!f_m0_ack && n < 50);
            chk("fp_m0_ack", f_m0_ack, 1);
            chk("fp_m1_ack", f_m1_ack, 0);
        end
        f_m0_cyc = 0; f_m0_stb = 0; f_m1_cyc = 0; f_m1_stb = 0;
        fp_done = 1;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        burst_t a;
        burst_t b;
        int     n;
        bit [1:0] mask;
        repeat (3) @(posedge clk);
        #2;
        check_reset("reset");
        #1 rst = 0;

        run_round(2'b01, 0, mk(16'h1234, 0, 2, 34, 0), mk('0, 0, 1, 1, 0), 0, 0);
        run_round(2'b11, 0, mk(16'h7001, 0, 3, 5, 0), mk(16'h0040, 1, 2, 6, 0), 0, 0);
        run_round(2'b11, 0, rnd_burst(0), rnd_burst(0), 0, 0);
        run_round(2'b11, 0, rnd_burst(0), rnd_burst(0), 0, 0);
        run_round(2'b01, 0, mk(16'h5555, 0, 1, 1, 1), mk('0, 0, 1, 1, 0), 0, 0);
        run_round(2'b11, 0, mk(16'h0101, 0, 2, 4, 0), mk(16'h0202, 1, 3, 12, 0), 0, 1);
        run_round(2'b01, 5, mk(16'h0303, 1, 2, 3, 0), mk('0, 0, 1, 1, 0), 0, 0);

        // Asynchronous reset while the controller is busy.
        issue_q.push_back(mk(16'h0ABC, 1, 1, 30, 0));
        plan_q.push_back(mk(16'h0ABC, 1, 1, 30, 0));
        @(posedge clk);
        #2 m0_cyc = 1; m0_stb = 1; m0_adr = 16'h0ABC; m0_we = 1;
        n = 0;
        while (!ctl_busy && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("rst_test_busy_seen", ctl_busy, 1);
        repeat (2) @(posedge clk);
        #3 rst = 1;
        #1 check_reset("async_rst");
        drop_req(0);
        last_grant = 1;
        repeat (2) @(posedge clk);
        #3 rst = 0;
        run_round(2'b11, 0, rnd_burst(0), rnd_burst(0), 0, 0);

        for (int k = 0; k < 30; k++) begin
            mask = 2'($urandom_range(1, 3));
            a = rnd_burst(1);
            b = rnd_burst(1);
            run_round(mask, 0, a, b, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
        end

        repeat (3) @(posedge clk);
        n = 0;
        while (!fp_done && n < 2000) begin
            @(posedge clk);
            n++;
        end
        chk("fp_finished", fp_done, 1);
        chk("issue_q_drained", issue_q.size(), 0);
        chk("resp_q_drained", resp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
